// File: rtl/rom_prog_loader_pkg.sv
// Shared types and constants for the ROM program loader.
// Loader FSM state encodings plus memory sizing and fill constants.
package rom_prog_loader_pkg;

    typedef enum logic [1:0] {
        LDR_IDLE    = 2'd0,
        LDR_COLLECT = 2'd1,
        LDR_WRITE   = 2'd2,
        LDR_DONE    = 2'd3
    } ldr_state_t;

    localparam int unsigned MEM_DEEPTH = 4096;
    localparam logic [31:0] ZERO_WORD  = '0;

endpackage

// File: rtl/rom_prog_loader_byte_packer.sv
// Packs an 8-bit byte stream into 32-bit little-endian words.
// word_valid flags the cycle in which the fourth byte of a word is accepted.
module rom_prog_loader_byte_packer
    import rom_prog_loader_pkg::*;
(
    input  logic        clk_100MHz,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0] idx_q;

    always_ff @(posedge clk_100MHz) begin
        if (rst || clear) begin
            idx_q <= '0;
            word  <= ZERO_WORD;
        end else if (byte_en) begin
            idx_q <= idx_q + 2'd1;
            case (idx_q)
                2'd0:    word[7:0]   <= byte_data;
                2'd1:    word[15:8]  <= byte_data;
                2'd2:    word[23:16] <= byte_data;
                default: word[31:24] <= byte_data;
            endcase
        end
    end

    assign word_valid = byte_en && (idx_q == 2'd3);

endmodule

// File: rtl/rom_prog_loader.sv
// Loads a byte stream into consecutive instruction-ROM words, holding the CPU
// for the whole session and keeping a running checksum of the words written.
module rom_prog_loader
    import rom_prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = MEM_DEEPTH,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk_100MHz,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              rom_w_ena_o,
    output logic [ADDR_W-1:0] rom_w_addr_o,
    output logic [31:0]       rom_w_data_o,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       checksum_o
);

    localparam int unsigned SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;

    ldr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  word_idx_q;
    logic [LEN_W-1:0]  words_next;
    logic [SUM_W-1:0]  end_word;
    logic              start_seen, start_bad, start_ok, start_rej;
    logic              byte_accept;
    logic              pack_clear;
    logic [31:0]       packed_word;
    logic              word_valid;

    // Bounds check runs one bit wider than either operand so the sum cannot wrap.
    assign end_word   = SUM_W'(base_addr_i[ADDR_W-1:2]) + SUM_W'(len_i);
    assign start_seen = start_i && (state_q == LDR_IDLE);
    assign start_bad  = (len_i == '0) || (base_addr_i[1:0] != 2'b00) ||
                        (end_word > SUM_W'(DEPTH));
    assign start_ok   = start_seen && !start_bad;
    assign start_rej  = start_seen && start_bad;
    assign words_next = word_idx_q + LEN_W'(1);

    assign byte_accept = byte_valid_i && byte_ready_o;
    assign pack_clear  = start_ok;

    rom_prog_loader_byte_packer u_packer (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .clear      (pack_clear),
        .byte_en    (byte_accept),
        .byte_data  (byte_data_i),
        .word       (packed_word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state_q    <= LDR_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            word_idx_q <= '0;
            checksum_o <= '0;
            err_o      <= 1'b0;
        end else begin
            state_q <= state_d;
            err_o   <= start_rej;
            if (start_ok) begin
                base_q     <= base_addr_i;
                len_q      <= len_i;
                word_idx_q <= '0;
                checksum_o <= '0;
            end else if (state_q == LDR_WRITE) begin
                word_idx_q <= words_next;
                checksum_o <= checksum_o + packed_word;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_ready_o = 1'b0;
        rom_w_ena_o  = 1'b0;
        rom_w_addr_o = '0;
        rom_w_data_o = ZERO_WORD;
        busy_o       = 1'b0;
        cpu_hold_o   = 1'b0;
        done_o       = 1'b0;
        case (state_q)
            LDR_IDLE: begin
                if (start_ok) state_d = LDR_COLLECT;
            end
            LDR_COLLECT: begin
                busy_o       = 1'b1;
                cpu_hold_o   = 1'b1;
                byte_ready_o = 1'b1;
                if (word_valid) state_d = LDR_WRITE;
            end
            LDR_WRITE: begin
                busy_o       = 1'b1;
                cpu_hold_o   = 1'b1;
                rom_w_ena_o  = 1'b1;
                rom_w_addr_o = base_q + ADDR_W'({word_idx_q, 2'b00});
                rom_w_data_o = packed_word;
                state_d      = (words_next < len_q) ? LDR_COLLECT : LDR_DONE;
            end
            LDR_DONE: begin
                busy_o     = 1'b1;
                cpu_hold_o = 1'b1;
                done_o     = 1'b1;
                state_d    = LDR_IDLE;
            end
            default: state_d = LDR_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rom_prog_loader.sv
// Scoreboard bench for rom_prog_loader: stimulus pushes expected writes,
// checksums and error pulses; a negedge monitor pops and compares them.
module tb_rom_prog_loader;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 4096;
    localparam int unsigned LEN_W  = 16;

    logic              clk;
    logic              rst;
    logic              start_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic [LEN_W-1:0]  len_i;
    logic              byte_valid_i;
    logic [7:0]        byte_data_i;
    logic              byte_ready_o;
    logic              rom_w_ena_o;
    logic [ADDR_W-1:0] rom_w_addr_o;
    logic [31:0]       rom_w_data_o;
    logic              cpu_hold_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [31:0]       checksum_o;

    rom_prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk_100MHz   (clk),
        .rst          (rst),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .len_i        (len_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .rom_w_ena_o  (rom_w_ena_o),
        .rom_w_addr_o (rom_w_addr_o),
        .rom_w_data_o (rom_w_data_o),
        .cpu_hold_o   (cpu_hold_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .checksum_o   (checksum_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks      = 0;
    int          fails       = 0;
    int          err_pending = 0;
    int          errs_seen   = 0;
    int          overlap     = 0;
    logic        prev_ena    = 1'b0;
    logic [63:0] wq[$];
    logic [31:0] dq[$];
    logic [63:0] exp_w;
    logic [31:0] wbuf[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write, done pulse and error pulse must match an expectation.
    always @(negedge clk) begin
        if (rom_w_ena_o === 1'b1) begin
            if (byte_valid_i === 1'b1 && byte_ready_o === 1'b1) overlap++;
            if (wq.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                         rom_w_addr_o, rom_w_data_o);
            end else begin
                exp_w = wq.pop_front();
                chk("write_addr", 64'(rom_w_addr_o), 64'(exp_w[63:32]));
                chk("write_data", 64'(rom_w_data_o), 64'(exp_w[31:0]));
            end
        end
        if (done_o === 1'b1) begin
            chk("done_after_write", 64'(prev_ena), 64'(1));
            if (dq.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_done: got done with checksum 0x%0h expected none", checksum_o);
            end else begin
                chk("checksum", 64'(checksum_o), 64'(dq.pop_front()));
            end
        end
        if (err_o === 1'b1) begin
            errs_seen++;
            if (err_pending == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_err: got err_o=1 expected 0");
            end else begin
                err_pending--;
            end
        end
        prev_ena = (rom_w_ena_o === 1'b1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] base, input logic [15:0] len, input logic ok);
        start_i     = 1'b1;
        base_addr_i = base;
        len_i       = len;
        step();
        start_i = 1'b0;
        chk("busy_after_start", 64'(busy_o), 64'(ok));
        chk("hold_after_start", 64'(cpu_hold_o), 64'(ok));
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap, input logic chk_hold);
        logic acc;
        acc          = 1'b0;
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        for (int t = 0; t < 40 && !acc; t++) begin
            @(negedge clk);
            if (byte_ready_o === 1'b1) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        byte_valid_i = 1'b0;
        if (!acc) chk("byte_accept_timeout", 64'(0), 64'(1));
        if (chk_hold) chk("hold_in_session", 64'(cpu_hold_o), 64'(1));
        for (int unsigned g = 0; g < gap; g++) step();
    endtask

    task automatic load(input logic [31:0] base, input logic [15:0] len, input int unsigned gap);
        logic [31:0] sum;
        logic [31:0] w;
        sum = '0;
        for (int i = 0; i < int'(len); i++) begin
            wq.push_back({base + 32'(4 * i), wbuf[i]});
            sum += wbuf[i];
        end
        dq.push_back(sum);
        do_start(base, len, 1'b1);
        for (int i = 0; i < int'(len); i++) begin
            w = wbuf[i];
            for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap, gap > 0);
        end
    endtask

    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int t = 0; t < 100 && !idle; t++) begin
            @(negedge clk);
            if (busy_o === 1'b0) idle = 1'b1;
        end
        if (!idle) chk("idle_timeout", 64'(0), 64'(1));
        step();
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            if (done_o === 1'b1) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic reject(input logic [31:0] base, input logic [15:0] len);
        err_pending++;
        do_start(base, len, 1'b0);
        step();
        step();
        chk("reject_busy", 64'(busy_o), 64'(0));
    endtask

    initial begin
        rst          = 1'b1;
        start_i      = 1'b0;
        base_addr_i  = '0;
        len_i        = '0;
        byte_valid_i = 1'b0;
        byte_data_i  = '0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs",
            64'({byte_ready_o, rom_w_ena_o, cpu_hold_o, busy_o, done_o, err_o}), 64'(0));
        chk("reset_addr_data", {rom_w_addr_o, rom_w_data_o}, 64'(0));
        chk("reset_checksum", 64'(checksum_o), 64'(0));
        step();

        // Case 1: reset after two bytes abandons the session; restart uses fresh bytes.
        do_start(32'h0, 16'd1, 1'b1);
        send_byte(8'hAA, 0, 1'b0);
        send_byte(8'hBB, 0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_busy", 64'(busy_o), 64'(0));
        chk("rst_mid_hold", 64'(cpu_hold_o), 64'(0));
        wbuf[0] = 32'h0403_0201;
        load(32'h10, 16'd1, 0);
        wait_idle();

        // Case 2: two words, bytes every cycle.
        wbuf[0] = 32'h1234_5678;
        wbuf[1] = 32'hDEAD_BEEF;
        load(32'h100, 16'd2, 0);
        wait_idle();
        chk("checksum_held", 64'(checksum_o), 64'(32'hF0E2_1567));

        // Case 3: same data with a byte only every third cycle.
        load(32'h200, 16'd2, 2);
        wait_idle();

        // Case 4: rejected starts, then the last legal word of the ROM.
        reject(32'h0, 16'd0);
        reject(32'h102, 16'd1);
        reject(32'(4 * (DEPTH - 1)), 16'd2);
        wbuf[0] = 32'hCAFE_F00D;
        load(32'(4 * (DEPTH - 1)), 16'd1, 0);
        wait_idle();

        // Case 5: start pulse during COLLECT must not disturb the session.
        wq.push_back({32'h300, 32'h0BAD_C0DE});
        dq.push_back(32'h0BAD_C0DE);
        do_start(32'h300, 16'd1, 1'b1);
        send_byte(8'hDE, 0, 1'b0);
        send_byte(8'hC0, 0, 1'b0);
        start_i     = 1'b1;
        base_addr_i = 32'h400;
        len_i       = 16'd3;
        step();
        start_i = 1'b0;
        send_byte(8'hAD, 0, 1'b0);
        send_byte(8'h0B, 0, 1'b0);
        wait_idle();

        // Case 6: new start in the IDLE cycle right after done.
        wbuf[0] = 32'hA5A5_0001;
        load(32'h20, 16'd1, 0);
        wait_done();
        wbuf[0] = 32'h4433_2211;
        load(32'h40, 16'd1, 0);
        wait_idle();

        repeat (5) step();
        chk("writes_pending", 64'(wq.size()), 64'(0));
        chk("done_pending", 64'(dq.size()), 64'(0));
        chk("err_pending", 64'(err_pending), 64'(0));
        chk("errs_seen", 64'(errs_seen), 64'(3));
        chk("ena_during_accept", 64'(overlap), 64'(0));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
